// File: rtl/dec_arb_pkg.sv
// Shared definitions for the decoded round-robin arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT, RELEASE), 2-bit encoding
//   NUM_REQ     : number of requesters sharing the decoded resource
//   IDX_W       : width of a requester index
package dec_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage : dec_arb_pkg

// File: rtl/dec_rr_arbiter_dec2_4.sv
// 2-to-4 decoder with enable, used to turn the registered owner index into
// one-hot select lines for the shared resource.
//   b  : 2-bit index to decode
//   en : enable; when low every output line is low
//   a  : one-hot decoded output (all zero when en=0)
module dec2_4 (
  input  logic [1:0] b,
  input  logic       en,
  output logic [3:0] a
);

  always_comb begin
    a = 4'b0000;
    if (en) begin
      a = 4'b0001 << b;
    end
  end

endmodule : dec2_4

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter sharing one 2-to-4 decoded resource among 4 requesters.
// The winner's index and a valid flag are registered and decoded by dec2_4 into
// a one-hot grant. A hold timer bounds each tenure while others are waiting.
//
// Handshake: req[i] is a level request held for as long as requester i wants
// the resource; gnt[i] high means requester i owns it this cycle. Dropping
// req[i] while owning ends the tenure; the grant falls for one dead cycle.
//
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   req      : level request per requester
//   gnt      : one-hot grant (combinational through the decoder only)
//   gnt_idx  : registered index of the current / most recent owner
//   gnt_vld  : registered, high while an owner holds the resource
//   timeout  : registered 1-cycle pulse during a force-ended RELEASE cycle
//   state    : debug view of the FSM state (arb_state_e encoding)
module dec_rr_arbiter
  import dec_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld,
  output logic               timeout,
  output logic [1:0]         state
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_d;
  logic                vld_d;
  logic                to_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_REQ-1:0]  others;

  // Scan from p upward with wrap; returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   p);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = p;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = p + IDX_W'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign {win_found, win_idx} = rr_pick(req, ptr_q);

  // Requests from anyone other than the current owner.
  assign others = req & ~(NUM_REQ'(1) << gnt_idx);

  always_comb begin
    state_d = state_q;
    idx_d   = gnt_idx;
    vld_d   = gnt_vld;
    to_d    = 1'b0;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        vld_d  = 1'b0;
        hold_d = '0;
        if (win_found) begin
          state_d = ST_GRANT;
          idx_d   = win_idx;
          vld_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        vld_d  = 1'b1;
        hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HOLD_W'(1);
        // A voluntary drop wins over an expiring timer, so timeout stays 0.
        if (!req[gnt_idx]) begin
          state_d = ST_RELEASE;
          vld_d   = 1'b0;
          hold_d  = '0;
          ptr_d   = gnt_idx + IDX_W'(1);
        end else if (hold_q == HOLD_LAST && others != '0) begin
          state_d = ST_RELEASE;
          vld_d   = 1'b0;
          to_d    = 1'b1;
          hold_d  = '0;
          ptr_d   = gnt_idx + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_idx <= idx_d;
      gnt_vld <= vld_d;
      timeout <= to_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign state = state_q;

  dec2_4 u_dec (
    .b  (gnt_idx),
    .en (gnt_vld),
    .a  (gnt)
  );

endmodule : dec_rr_arbiter

// File: tb/tb_dec_rr_arbiter.sv
// Self-checking bench for dec_rr_arbiter. A behavioural model tracks owner,
// tenure length and rotating priority with plain integers and predicts every
// output each cycle; directed scenarios are followed by randomized requests.
module tb_dec_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  // Reference model state
  int m_owner;   // -1 when nobody owns the resource
  int m_cycles;  // grant cycles of the current tenure so far
  int m_prio;    // first requester scanned at the next arbitration
  int m_last;    // most recent owner (what gnt_idx shows)
  bit m_to;
  bit m_dead;

  dec_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout),
    .state   (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200us");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_cycles = 0;
    m_prio   = 0;
    m_last   = 0;
    m_to     = 1'b0;
    m_dead   = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r);
    if (m_owner >= 0) begin
      m_to = 1'b0;
      if (!r[m_owner]) begin
        m_prio = (m_owner + 1) % 4; m_owner = -1; m_dead = 1'b1;
      end else if (m_cycles >= MAX_HOLD && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
        m_prio = (m_owner + 1) % 4; m_owner = -1; m_dead = 1'b1; m_to = 1'b1;
      end else begin
        m_cycles++;
      end
    end else begin
      m_to   = 1'b0;
      m_dead = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_prio + k) % 4;
        if (m_owner < 0 && r[j]) begin
          m_owner = j; m_cycles = 1; m_last = j;
        end
      end
    end
  endtask

  function automatic logic [3:0] model_gnt();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_owner >= 0) return 2'd1;
    if (m_dead) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check_outputs();
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check_eq("gnt", gnt, e);
    check_eq("gnt_vld", gnt_vld, m_owner >= 0);
    check_eq("gnt_idx", gnt_idx, m_last[1:0]);
    check_eq("timeout", timeout, m_to);
    check_eq("state", state, model_state());
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(req);
    exp_q.push_back(model_gnt());
    #1;
    check_outputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vld_cnt, to_cnt, k;
    bit prev_vld;
    int exp_owner[5];
    exp_owner = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    #1;
    check_eq("rst_gnt", gnt, 4'b0000);
    check_eq("rst_vld", gnt_vld, 0);
    check_eq("rst_idx", gnt_idx, 0);
    check_eq("rst_to", timeout, 0);
    check_eq("rst_state", state, 0);
    cycles(2);
    rst_n = 1'b1;

    // Idle with no requests
    cycles(5);

    // Single request from requester 2, then release; ptr moves to 3
    req = 4'b0100;
    cycle();
    check_eq("r2_idx", gnt_idx, 2);
    check_eq("r2_gnt", gnt, 4'b0100);
    cycles(2);
    req = 4'b0000;
    cycle();
    check_eq("r2_dead_vld", gnt_vld, 0);
    check_eq("r2_dead_idx", gnt_idx, 2);
    cycle();
    check_eq("r2_idle", state, 0);
    req = 4'b1001;
    cycle();
    check_eq("ptr3_pick", gnt_idx, 3);
    req = 4'b0000;
    cycles(3);

    // All four requesting: rotation with hold-timer expiry
    sync_reset();
    req = 4'b1111;
    vld_cnt = 0; to_cnt = 0; k = 0; prev_vld = 1'b0;
    for (int c = 1; c <= 37; c++) begin
      cycle();
      if (gnt_vld && !prev_vld) begin
        if (k < 5) check_eq("rot_owner", gnt_idx, exp_owner[k]);
        k++;
      end
      prev_vld = gnt_vld;
      if (c <= 36) begin
        if (gnt_vld) vld_cnt++;
        if (timeout) to_cnt++;
      end
    end
    check_eq("rot_tenures", k, 5);
    check_eq("rot_vld_cycles", vld_cnt, 32);
    check_eq("rot_timeouts", to_cnt, 4);

    // Lone requester keeps the grant indefinitely
    req = 4'b0000;
    cycles(3);
    req = 4'b0001;
    vld_cnt = 0; to_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (gnt == 4'b0001) vld_cnt++;
      if (timeout) to_cnt++;
    end
    check_eq("lone_gnt_cycles", vld_cnt, 40);
    check_eq("lone_timeouts", to_cnt, 0);

    // Owner 1 drops on the expiry cycle while 3 waits -> normal release
    req = 4'b0000;
    cycles(3);
    req = 4'b0010;
    cycle();
    check_eq("o1_idx", gnt_idx, 1);
    req = 4'b1010;
    cycles(7);
    req = 4'b1000;
    cycle();
    check_eq("o1_rel_state", state, 2);
    check_eq("o1_rel_to", timeout, 0);
    cycle();
    check_eq("o1_next_idx", gnt_idx, 3);
    check_eq("o1_next_gnt", gnt, 4'b1000);
    cycles(2);

    // Asynchronous reset in the middle of a grant
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_gnt", gnt, 4'b0000);
    check_eq("async_vld", gnt_vld, 0);
    check_eq("async_state", state, 0);
    cycles(2);
    rst_n = 1'b1;
    cycle();
    check_eq("post_rst_idx", gnt_idx, 3);
    check_eq("post_rst_gnt", gnt, 4'b1000);

    // Randomized level requests
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (req[b]) begin
          if ($urandom_range(0, 7) == 0) req[b] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[b] = 1'b1;
        end
      end
      if (c == 400) sync_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dec_rr_arbiter
